digit_entry_buffer: RTL
=======================

// Module: digit_entry_buffer
// PURPOSE
//  Parametrised keypad operand-entry buffer for the calculator datapath. Accepts
//  decoded key commands, shifts BCD digits into an N-digit entry field, commits
//  the first operand to a held field, and accepts a result load.
//  Drives the 2*DIGITS-digit display bus: held field upper, entry field lower.
// PARAMETERS
//  DIGITS  2      digits per field (1..8)
//  BLANK   4'd13  BCD code for a blank seven-segment digit
// PORTS
//  clk        in   1            system clock, rising edge
//  rst        in   1            asynchronous reset, active-high
//  cmd_valid  in   1            command strobe, one cycle per key press
//  cmd_op     in   3            0 NOP,1 DIGIT,2 BKSP,3 COMMIT,4 CLR_ENTRY,5 CLR_ALL; 6,7 illegal
//  cmd_digit  in   4            BCD value for DIGIT; legal range 0..9
//  res_valid  in   1            result load strobe
//  res_value  in   4*DIGITS     result digits; digit0 in bits [3:0]
//  disp       out  8*DIGITS     {held[DIGITS-1:0], entry[DIGITS-1:0]}; entry digit0 in [3:0]
//  entry_cnt  out  clog2(DIGITS+1)  number of significant digits in the entry field
//  mode       out  2            0 ENTER_A, 1 ENTER_B, 2 RESULT
//  full       out  1            entry_cnt==DIGITS; combinational from registers
//  cmd_rej    out  1            registered one-cycle pulse; previous command was rejected
// BEHAVIOUR
//  - Reset: all disp digits=BLANK, entry_cnt=0, mode=ENTER_A, cmd_rej=0.
//  - All updates occur on the clk edge that samples the strobe. Effects are visible the next cycle.
//  - res_valid has priority: entry<=res_value, entry_cnt<=DIGITS, mode<=RESULT, held unchanged.
//    If cmd_valid is also high in that cycle, the command is dropped and cmd_rej pulses.
//  - DIGIT in ENTER_A/ENTER_B: entry shifts up one place, digit0<=cmd_digit, cnt+1.
//    Rejected if full or cmd_digit>9.
//  - DIGIT in RESULT: held<=BLANK, entry<={BLANK..,cmd_digit}, cnt=1, mode<=ENTER_A.
//  - BKSP: entry shifts down, top digit<=BLANK, cnt-1. Rejected if cnt==0 or mode==RESULT.
//  - COMMIT:
//    ENTER_A with cnt>0: held<=entry, entry<=BLANK, cnt=0, mode<=ENTER_B.
//    RESULT: same move, which chains the result into the next operand.
//    Otherwise rejected.
//  - CLR_ENTRY: entry<=BLANK, cnt=0. mode is unchanged, except RESULT goes to ENTER_A.
//  - CLR_ALL: same state as reset. Never rejected.
//  - Illegal op (6,7): rejected. NOP: no effect, no reject.
//  - Rejection never alters field, cnt or mode. cmd_rej is otherwise 0.
//  - Reset asserted mid-sequence overrides every strobe immediately (asynchronous).
// CONFIGURATION
//  DIGIT_ENTRY_LZ_SUPPRESS_EN defined:
//    DIGIT 0 with cnt==0 writes digit0=0 but leaves cnt=0, so the next digit overwrites it.
//    A zero-only entry is therefore never shifted.
//    The COMMIT cnt>0 check is relaxed: an entry showing "0" counts as an operand.
//  Undefined: 0 is an ordinary digit and increments cnt.
// STRUCTURE
//  - Package digit_entry_pkg:
//    op-code localparams (OP_NOP..OP_CLR_ALL), mode encodings (M_ENTER_A/M_ENTER_B/M_RESULT),
//    BCD_BLANK default.
//  - Sub-module digit_shift_field: one DIGITS-deep BCD register with parallel load,
//    shift-in-low, shift-out-low-with-blank-fill and clear.
//    Used for the entry field; the held field is a plain load register.
//  - The top level contains the mode FSM, the counter, reject logic and output packing.
// TESTING (DIGITS=2, BLANK=13)
//  1. Reset, then DIGIT 4, DIGIT 7
//     -> disp=16'hDD47, cnt=2, full=1. A third DIGIT 1 -> cmd_rej=1, disp unchanged.
//  2. Entry 47, COMMIT, DIGIT 3
//     -> disp=16'h47D3, mode=ENTER_B. A COMMIT here -> cmd_rej=1.
//  3. Entry 47, BKSP, BKSP, BKSP
//     -> disp DDD4, then DDDD. The third BKSP is rejected and cnt stays 0.
//  4. res_valid with res_value=8'h12 together with cmd_valid DIGIT 5
//     -> disp=hold|12, mode=RESULT, cmd_rej=1.
//     Then DIGIT 9 -> disp=16'hDDD9, mode=ENTER_A.
//  5. RESULT 12, COMMIT -> disp=16'h12DD, mode=ENTER_B.
//     DIGIT 10 or op 7 -> cmd_rej=1.
//  6. Assert rst asynchronously between edges with entry 47
//     -> disp=16'hDDDD immediately. Repeat test 1 with and without DIGIT_ENTRY_LZ_SUPPRESS_EN
//     using DIGIT 0, DIGIT 5: expect DDD5/cnt1 with the macro, DD05/cnt2 without.

Source files
------------

// File: rtl/digit_entry_buffer_pkg.sv
// Shared op codes, mode encodings and BCD helpers for the keypad operand-entry buffer.
package digit_entry_pkg;

  localparam logic [2:0] OP_NOP       = 3'd0;
  localparam logic [2:0] OP_DIGIT     = 3'd1;
  localparam logic [2:0] OP_BKSP      = 3'd2;
  localparam logic [2:0] OP_COMMIT    = 3'd3;
  localparam logic [2:0] OP_CLR_ENTRY = 3'd4;
  localparam logic [2:0] OP_CLR_ALL   = 3'd5;

  typedef enum logic [1:0] {
    M_ENTER_A = 2'd0,
    M_ENTER_B = 2'd1,
    M_RESULT  = 2'd2
  } mode_e;

  localparam logic [3:0] BCD_BLANK = 4'd13;
  localparam logic [3:0] BCD_MAX   = 4'd9;

  function automatic logic is_bcd(input logic [3:0] d);
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/digit_shift_field.sv
// DIGITS-deep BCD register with clear, parallel load, shift-in-low and
// shift-out-low with blank fill at the top. Priority: clear, load, shift-in, shift-out.
module digit_shift_field
  import digit_entry_pkg::*;
#(
  parameter int         DIGITS = 2,
  parameter logic [3:0] BLANK  = BCD_BLANK
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  load_i,
  input  logic [4*DIGITS-1:0]   load_val_i,
  input  logic                  shift_in_i,
  input  logic [3:0]            digit_i,
  input  logic                  shift_out_i,
  output logic [4*DIGITS-1:0]   field_o
);

  logic [DIGITS-1:0][3:0] field_q;
  logic [DIGITS-1:0][3:0] field_d;

  // Next field value from the highest-priority request.
  always_comb begin
    field_d = field_q;
    if (clear_i) begin
      for (int i = 0; i < DIGITS; i++) begin
        field_d[i] = BLANK;
      end
    end else if (load_i) begin
      field_d = load_val_i;
    end else if (shift_in_i) begin
      for (int i = DIGITS - 1; i > 0; i--) begin
        field_d[i] = field_q[i-1];
      end
      field_d[0] = digit_i;
    end else if (shift_out_i) begin
      for (int i = 0; i < DIGITS - 1; i++) begin
        field_d[i] = field_q[i+1];
      end
      field_d[DIGITS-1] = BLANK;
    end else begin
      field_d = field_q;
    end
  end

  // Field register, blank after reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      field_q <= {DIGITS{BLANK}};
    end else begin
      field_q <= field_d;
    end
  end

  assign field_o = field_q;

endmodule

// File: rtl/digit_entry_buffer.sv
// Keypad operand-entry buffer: entry shift field, held operand, mode FSM and reject pulse.
// Optional feature macro: DIGIT_ENTRY_LZ_SUPPRESS_EN (leading-zero suppression on entry).
module digit_entry_buffer
  import digit_entry_pkg::*;
#(
  parameter int         DIGITS = 2,
  parameter logic [3:0] BLANK  = BCD_BLANK
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  input  logic [2:0]                  cmd_op,
  input  logic [3:0]                  cmd_digit,
  input  logic                        res_valid,
  input  logic [4*DIGITS-1:0]         res_value,
  output logic [8*DIGITS-1:0]         disp,
  output logic [$clog2(DIGITS+1)-1:0] entry_cnt,
  output logic [1:0]                  mode,
  output logic                        full,
  output logic                        cmd_rej
);

  localparam int CW = $clog2(DIGITS + 1);
  localparam logic [CW-1:0]       CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0]       CNT_ONE   = CW'(1);
  localparam logic [CW-1:0]       CNT_FULL  = CW'(DIGITS);
  localparam logic [4*DIGITS-1:0] ALL_BLANK = {DIGITS{BLANK}};

`ifdef DIGIT_ENTRY_LZ_SUPPRESS_EN
  localparam bit LZ_EN = 1'b1;
`else
  localparam bit LZ_EN = 1'b0;
`endif

  logic [4*DIGITS-1:0] held_q, held_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  mode_e               mode_q, mode_d;
  logic                rej_q, rej_d;

  logic [4*DIGITS-1:0] entry_s;
  logic [4*DIGITS-1:0] fresh_s;
  logic [4*DIGITS-1:0] load_val_s;
  logic                clear_s, load_s, shift_in_s, shift_out_s;
  logic                zero_key_s, operand_s;

  // Single-digit entry image used when a new operand starts from one key.
  always_comb begin
    fresh_s      = ALL_BLANK;
    fresh_s[3:0] = cmd_digit;
  end

  assign zero_key_s = LZ_EN && (cmd_digit == 4'd0);
  // With suppression, a lone "0" (cnt still 0) is still a committable operand.
  assign operand_s  = (cnt_q != CNT_ZERO) || (LZ_EN && (entry_s[3:0] == 4'd0));

  // Command decode: next held/count/mode, entry field controls and reject pulse.
  always_comb begin
    held_d      = held_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    rej_d       = 1'b0;
    clear_s     = 1'b0;
    load_s      = 1'b0;
    load_val_s  = res_value;
    shift_in_s  = 1'b0;
    shift_out_s = 1'b0;
    if (res_valid) begin
      load_s     = 1'b1;
      load_val_s = res_value;
      cnt_d      = CNT_FULL;
      mode_d     = M_RESULT;
      rej_d      = cmd_valid;
    end else if (cmd_valid) begin
      case (cmd_op)
        OP_NOP: begin
          rej_d = 1'b0;
        end
        OP_DIGIT: begin
          if (!is_bcd(cmd_digit)) begin
            rej_d = 1'b1;
          end else if (mode_q == M_RESULT) begin
            held_d     = ALL_BLANK;
            load_s     = 1'b1;
            load_val_s = fresh_s;
            cnt_d      = zero_key_s ? CNT_ZERO : CNT_ONE;
            mode_d     = M_ENTER_A;
          end else if (cnt_q == CNT_FULL) begin
            rej_d = 1'b1;
          end else if (LZ_EN && (cnt_q == CNT_ZERO)) begin
            // Overwrite any suppressed leading zero rather than shifting it up.
            load_s     = 1'b1;
            load_val_s = fresh_s;
            cnt_d      = zero_key_s ? CNT_ZERO : CNT_ONE;
          end else begin
            shift_in_s = 1'b1;
            cnt_d      = cnt_q + CNT_ONE;
          end
        end
        OP_BKSP: begin
          if ((cnt_q == CNT_ZERO) || (mode_q == M_RESULT)) begin
            rej_d = 1'b1;
          end else begin
            shift_out_s = 1'b1;
            cnt_d       = cnt_q - CNT_ONE;
          end
        end
        OP_COMMIT: begin
          if ((mode_q == M_RESULT) || ((mode_q == M_ENTER_A) && operand_s)) begin
            held_d  = entry_s;
            clear_s = 1'b1;
            cnt_d   = CNT_ZERO;
            mode_d  = M_ENTER_B;
          end else begin
            rej_d = 1'b1;
          end
        end
        OP_CLR_ENTRY: begin
          clear_s = 1'b1;
          cnt_d   = CNT_ZERO;
          if (mode_q == M_RESULT) begin
            mode_d = M_ENTER_A;
          end else begin
            mode_d = mode_q;
          end
        end
        OP_CLR_ALL: begin
          held_d  = ALL_BLANK;
          clear_s = 1'b1;
          cnt_d   = CNT_ZERO;
          mode_d  = M_ENTER_A;
        end
        default: begin
          rej_d = 1'b1;
        end
      endcase
    end else begin
      rej_d = 1'b0;
    end
  end

  // Held operand, digit count, mode state and reject pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held_q <= ALL_BLANK;
      cnt_q  <= CNT_ZERO;
      mode_q <= M_ENTER_A;
      rej_q  <= 1'b0;
    end else begin
      held_q <= held_d;
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
      rej_q  <= rej_d;
    end
  end

  digit_shift_field #(
    .DIGITS (DIGITS),
    .BLANK  (BLANK)
  ) u_entry (
    .clk_i       (clk),
    .rst_i       (rst),
    .clear_i     (clear_s),
    .load_i      (load_s),
    .load_val_i  (load_val_s),
    .shift_in_i  (shift_in_s),
    .digit_i     (cmd_digit),
    .shift_out_i (shift_out_s),
    .field_o     (entry_s)
  );

  assign disp      = {held_q, entry_s};
  assign entry_cnt = cnt_q;
  assign mode      = mode_q;
  assign full      = (cnt_q == CNT_FULL);
  assign cmd_rej   = rej_q;

endmodule
